// File: rtl/alu_share_arbiter_pkg.sv
// Shared constants for the ALU share arbiter.
//   - ALUctl width and requester ids
//   - ALUctl[6:4] branch-compare selections, reused unchanged from the core
//   - helper returning the requester that did not win last
package alu_share_arbiter_pkg;

  localparam int ALUCTL_W = 7;

  localparam logic ARB_ID_EXEC = 1'b0;
  localparam logic ARB_ID_AUX  = 1'b1;

  typedef enum logic [2:0] {
    ALUCTL_6TO4_NONE = 3'd0,
    ALUCTL_6TO4_BEQ  = 3'd1,
    ALUCTL_6TO4_BNE  = 3'd2,
    ALUCTL_6TO4_BLT  = 3'd3,
    ALUCTL_6TO4_BGE  = 3'd4,
    ALUCTL_6TO4_BLTU = 3'd5,
    ALUCTL_6TO4_BGEU = 3'd6
  } branch_sel_e;

  function automatic logic [1:0] rr_pick(input logic last_id);
    return last_id ? 2'b01 : 2'b10;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, reset : clock, synchronous active-high reset
//   req[1:0]   : request vector
//   advance    : current grant was taken this cycle; remember the winner
//   grant[1:0] : one-hot grant, zero when nothing requests
// last_grant resets to the aux id so the exec requester wins first contention.
module rr_arb2
  import alu_share_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= ARB_ID_AUX;
    end else if (advance) begin
      last_grant <= grant[1];
    end
  end

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = rr_pick(last_grant);
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between the execute path (r0) and the
// branch/aux path (r1).
//   r*_valid/ready/aluctl/a/b : requester handshakes and operations
//   alu_ctl/a/b, alu_out, alu_branch_enable : external ALU connection
//   rsp_*      : one-entry registered response buffer tagged with requester id
//   grant_cnt* : saturating counts of accepted operations
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTL_W  = ALUCTL_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [CTL_W-1:0]  r0_aluctl,
  input  logic [DATA_W-1:0] r0_a,
  input  logic [DATA_W-1:0] r0_b,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [CTL_W-1:0]  r1_aluctl,
  input  logic [DATA_W-1:0] r1_a,
  input  logic [DATA_W-1:0] r1_b,
  output logic [CTL_W-1:0]  alu_ctl,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_branch_enable,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_aluout,
  output logic              rsp_branch_enable,
  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1
);

  logic [1:0] grant;
  logic       can_accept;
  logic       accept0;
  logic       accept1;
  logic       accept;

  // Buffer refills in the same cycle it drains.
  assign can_accept = !rsp_valid || rsp_ready;

  assign r0_ready = grant[0] && can_accept && !reset;
  assign r1_ready = grant[1] && can_accept && !reset;
  assign accept0  = r0_valid && r0_ready;
  assign accept1  = r1_valid && r1_ready;
  assign accept   = accept0 || accept1;

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .reset   (reset),
    .req     ({r1_valid, r0_valid}),
    .advance (accept),
    .grant   (grant)
  );

  // ALU sees r0 unless r1 holds the grant; result is captured the same cycle.
  assign alu_ctl = grant[1] ? r1_aluctl : r0_aluctl;
  assign alu_a   = grant[1] ? r1_a      : r0_a;
  assign alu_b   = grant[1] ? r1_b      : r0_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid         <= 1'b0;
      rsp_id            <= ARB_ID_EXEC;
      rsp_aluout        <= '0;
      rsp_branch_enable <= 1'b0;
    end else if (accept) begin
      rsp_valid         <= 1'b1;
      rsp_id            <= accept1 ? ARB_ID_AUX : ARB_ID_EXEC;
      rsp_aluout        <= alu_out;
      rsp_branch_enable <= alu_branch_enable;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (accept0 && (grant_cnt0 != {CNT_W{1'b1}})) begin
        grant_cnt0 <= grant_cnt0 + 1'b1;
      end
      if (accept1 && (grant_cnt1 != {CNT_W{1'b1}})) begin
        grant_cnt1 <= grant_cnt1 + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, rsp_ready;
  logic        r0_valid, r1_valid;
  logic [6:0]  r0_aluctl, r1_aluctl;
  logic [31:0] r0_a, r0_b, r1_a, r1_b;

  logic        a_r0_ready, a_r1_ready, a_rsp_valid, a_rsp_id, a_rsp_be, a_alu_be;
  logic [6:0]  a_alu_ctl;
  logic [31:0] a_alu_a, a_alu_b, a_alu_out, a_rsp_aluout;
  logic [15:0] a_cnt0, a_cnt1;

  logic        b_r0_ready, b_r1_ready, b_rsp_valid, b_rsp_id, b_rsp_be, b_alu_be;
  logic [6:0]  b_alu_ctl;
  logic [31:0] b_alu_a, b_alu_b, b_alu_out, b_rsp_aluout;
  logic [3:0]  b_cnt0, b_cnt1;

  function automatic logic [31:0] alu_res(input logic [6:0] c, input logic [31:0] x, input logic [31:0] y);
    return x + y + {25'd0, c};
  endfunction

  function automatic logic alu_br(input logic [6:0] c, input logic [31:0] x, input logic [31:0] y);
    case (c[6:4])
      3'd1:    return x == y;
      3'd2:    return x != y;
      3'd3:    return $signed(x) < $signed(y);
      3'd4:    return $signed(x) >= $signed(y);
      3'd5:    return x < y;
      3'd6:    return x >= y;
      default: return 1'b0;
    endcase
  endfunction

  assign a_alu_out = alu_res(a_alu_ctl, a_alu_a, a_alu_b);
  assign a_alu_be  = alu_br(a_alu_ctl, a_alu_a, a_alu_b);
  assign b_alu_out = alu_res(b_alu_ctl, b_alu_a, b_alu_b);
  assign b_alu_be  = alu_br(b_alu_ctl, b_alu_a, b_alu_b);

  alu_share_arbiter #(.DATA_W(32), .CTL_W(7), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_ready(a_r0_ready), .r0_aluctl(r0_aluctl), .r0_a(r0_a), .r0_b(r0_b),
    .r1_valid(r1_valid), .r1_ready(a_r1_ready), .r1_aluctl(r1_aluctl), .r1_a(r1_a), .r1_b(r1_b),
    .alu_ctl(a_alu_ctl), .alu_a(a_alu_a), .alu_b(a_alu_b),
    .alu_out(a_alu_out), .alu_branch_enable(a_alu_be),
    .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(a_rsp_id),
    .rsp_aluout(a_rsp_aluout), .rsp_branch_enable(a_rsp_be),
    .grant_cnt0(a_cnt0), .grant_cnt1(a_cnt1)
  );

  alu_share_arbiter #(.DATA_W(32), .CTL_W(7), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_ready(b_r0_ready), .r0_aluctl(r0_aluctl), .r0_a(r0_a), .r0_b(r0_b),
    .r1_valid(r1_valid), .r1_ready(b_r1_ready), .r1_aluctl(r1_aluctl), .r1_a(r1_a), .r1_b(r1_b),
    .alu_ctl(b_alu_ctl), .alu_a(b_alu_a), .alu_b(b_alu_b),
    .alu_out(b_alu_out), .alu_branch_enable(b_alu_be),
    .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(b_rsp_id),
    .rsp_aluout(b_rsp_aluout), .rsp_branch_enable(b_rsp_be),
    .grant_cnt0(b_cnt0), .grant_cnt1(b_cnt1)
  );

  int compared = 0;
  int mismatched = 0;

  // reference model: contents of the response slot, who was served last, op counts
  bit          m_valid, m_id, m_be, m_last;
  logic [31:0] m_out;
  int          m_cnt0, m_cnt1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_id = 0; m_be = 0; m_out = '0; m_last = 1; m_cnt0 = 0; m_cnt1 = 0;
  endtask

  task automatic cycle(input bit rst, input bit rr,
                       input bit v0, input logic [6:0] c0, input logic [31:0] x0, input logic [31:0] y0,
                       input bit v1, input logic [6:0] c1, input logic [31:0] x1, input logic [31:0] y1,
                       output bit acc0, output bit acc1);
    bit can, pick1;
    reset = rst; rsp_ready = rr;
    r0_valid = v0; r0_aluctl = c0; r0_a = x0; r0_b = y0;
    r1_valid = v1; r1_aluctl = c1; r1_a = x1; r1_b = y1;
    #1;
    can = !m_valid || rr;
    // under contention serve whoever was not served last
    if (v0 && v1) pick1 = (m_last == 0);
    else          pick1 = v1;
    acc0 = !rst && can && v0 && !pick1;
    acc1 = !rst && can && v1 && pick1;
    chk("r0_ready", a_r0_ready, acc0);
    chk("r1_ready", a_r1_ready, acc1);
    chk("b_r0_ready", b_r0_ready, acc0);
    chk("b_r1_ready", b_r1_ready, acc1);
    chk("alu_ctl", a_alu_ctl, pick1 ? c1 : c0);
    chk("alu_a", a_alu_a, pick1 ? x1 : x0);
    chk("alu_b", a_alu_b, pick1 ? y1 : y0);
    if (rst) begin
      model_reset();
    end else if (acc0 || acc1) begin
      m_valid = 1;
      m_id    = acc1;
      m_last  = acc1;
      m_out   = acc1 ? alu_res(c1, x1, y1) : alu_res(c0, x0, y0);
      m_be    = acc1 ? alu_br(c1, x1, y1)  : alu_br(c0, x0, y0);
      if (acc0) m_cnt0 = sat(m_cnt0 + 1, 65535);
      else      m_cnt1 = sat(m_cnt1 + 1, 65535);
    end else if (m_valid && rr) begin
      m_valid = 0;
    end
    @(posedge clk); #1;
    chk("rsp_valid", a_rsp_valid, m_valid);
    chk("rsp_id", a_rsp_id, m_id);
    chk("rsp_aluout", a_rsp_aluout, m_out);
    chk("rsp_be", a_rsp_be, m_be);
    chk("grant_cnt0", a_cnt0, m_cnt0);
    chk("grant_cnt1", a_cnt1, m_cnt1);
    chk("b_rsp_valid", b_rsp_valid, m_valid);
    chk("b_rsp_aluout", b_rsp_aluout, m_out);
    chk("b_grant_cnt0", b_cnt0, sat(m_cnt0, 15));
    chk("b_grant_cnt1", b_cnt1, sat(m_cnt1, 15));
  endtask

  localparam logic [6:0] C_BEQ  = {ALUCTL_6TO4_BEQ,  4'b0110};
  localparam logic [6:0] C_BNE  = {ALUCTL_6TO4_BNE,  4'b0110};
  localparam logic [6:0] C_BLTU = {ALUCTL_6TO4_BLTU, 4'b0110};
  localparam logic [6:0] C_ADD  = {ALUCTL_6TO4_NONE, 4'b0010};

  initial begin
    bit d0, d1;
    bit pv0, pv1;
    logic [6:0]  pc0, pc1;
    logic [31:0] pa0, pb0, pa1, pb1;

    reset = 1; rsp_ready = 0;
    r0_valid = 0; r0_aluctl = '0; r0_a = '0; r0_b = '0;
    r1_valid = 0; r1_aluctl = '0; r1_a = '0; r1_b = '0;
    model_reset();
    @(posedge clk); #1;
    chk("rst_rsp_valid", a_rsp_valid, 0);
    chk("rst_rsp_id", a_rsp_id, 0);
    chk("rst_rsp_aluout", a_rsp_aluout, 0);
    chk("rst_rsp_be", a_rsp_be, 0);
    chk("rst_cnt0", a_cnt0, 0);
    chk("rst_cnt1", a_cnt1, 0);
    chk("rst_r0_ready", a_r0_ready, 0);

    // r0 BEQ 0x0F vs 0x55: not equal
    cycle(0, 1, 1, C_BEQ, 32'h0F, 32'h55, 0, C_ADD, 0, 0, d0, d1);
    chk("beq_accept", d0, 1);
    chk("beq_id", a_rsp_id, 0);
    chk("beq_be", a_rsp_be, 0);
    // r1 alone, BNE 0x0E vs 0x55: taken
    cycle(0, 1, 0, C_ADD, 0, 0, 1, C_BNE, 32'h0E, 32'h55, d0, d1);
    chk("bne_id", a_rsp_id, 1);
    chk("bne_be", a_rsp_be, 1);
    chk("bne_valid", a_rsp_valid, 1);

    // continuous contention after reset alternates starting with r0
    cycle(1, 1, 0, C_ADD, 0, 0, 0, C_ADD, 0, 0, d0, d1);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 1, C_ADD, 32'(100 + i), 32'd1, 1, C_ADD, 32'(200 + i), 32'd2, d0, d1);
      chk("ctn_id", a_rsp_id, i % 2);
    end
    chk("ctn_cnt0", a_cnt0, 2);
    chk("ctn_cnt1", a_cnt1, 2);

    // backpressure with full buffer: nothing moves
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 1, C_ADD, 32'h500, 32'h1, 1, C_ADD, 32'h600, 32'h2, d0, d1);
      chk("bp_id", a_rsp_id, 1);
      chk("bp_aluout", a_rsp_aluout, alu_res(C_ADD, 32'd203, 32'd2));
    end
    cycle(0, 1, 1, C_ADD, 32'h500, 32'h1, 1, C_ADD, 32'h600, 32'h2, d0, d1);
    chk("bp_resume_id", a_rsp_id, 0);
    chk("bp_resume_cnt0", a_cnt0, 3);

    // reset while full and both valid
    cycle(1, 0, 1, C_ADD, 32'h7, 32'h8, 1, C_ADD, 32'h9, 32'hA, d0, d1);
    chk("rstfull_valid", a_rsp_valid, 0);
    chk("rstfull_cnt0", a_cnt0, 0);
    chk("rstfull_cnt1", a_cnt1, 0);
    cycle(0, 1, 1, C_ADD, 32'h7, 32'h8, 1, C_ADD, 32'h9, 32'hA, d0, d1);
    chk("rstfull_first_id", a_rsp_id, 0);

    // saturation on the narrow counter
    cycle(1, 1, 0, C_ADD, 0, 0, 0, C_ADD, 0, 0, d0, d1);
    for (int i = 0; i < 20; i++) begin
      cycle(0, 1, 1, C_BLTU, 32'd0, 32'd2, 0, C_ADD, 0, 0, d0, d1);
      chk("bltu_be", a_rsp_be, 1);
    end
    chk("sat_b_cnt0", b_cnt0, 15);
    chk("sat_a_cnt0", a_cnt0, 20);

    // random traffic; requesters hold their op until accepted
    pv0 = 0; pv1 = 0;
    pc0 = '0; pa0 = '0; pb0 = '0; pc1 = '0; pa1 = '0; pb1 = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pv0 && $urandom_range(0, 3) != 0) begin
        pv0 = 1; pc0 = {3'($urandom_range(0, 7)), 4'($urandom)};
        pa0 = $urandom; pb0 = ($urandom_range(0, 3) == 0) ? pa0 : $urandom;
      end
      if (!pv1 && $urandom_range(0, 3) != 0) begin
        pv1 = 1; pc1 = {3'($urandom_range(0, 7)), 4'($urandom)};
        pa1 = $urandom; pb1 = ($urandom_range(0, 3) == 0) ? pa1 : $urandom;
      end
      cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
            pv0, pc0, pa0, pb0, pv1, pc1, pa1, pb1, d0, d1);
      if (d0) pv0 = 0;
      if (d1) pv1 = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single combinational RV32I ALU between two requesters.
  - Requester 0: main execute path.
  - Requester 1: branch-resolution / auxiliary path.
- Arbitrates round-robin over valid/ready handshakes and drives the ALU's ALUctl/A/B from the granted requester.
- Registers ALUOut and Branch_Enable into a one-entry response buffer tagged with the requester id.
- Sits between the requesters and the ALU instance; the ALU itself stays external and unmodified.

Parameters:
- DATA_W, 32, operand/result width.
- CTL_W, 7, ALUctl width.
- CNT_W, 16, width of per-requester saturating grant counters.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- r0_valid  in  1  requester 0 has an operation.
- r0_ready  out  1  requester 0 operation accepted this cycle.
- r0_aluctl  in  CTL_W  requester 0 ALUctl (bits 6:4 carry the branch-compare selection).
- r0_a  in  DATA_W  requester 0 operand A.
- r0_b  in  DATA_W  requester 0 operand B.
- r1_valid, r1_ready, r1_aluctl, r1_a, r1_b  as r0, for requester 1.
- alu_ctl  out  CTL_W  to ALU ALUctl.
- alu_a  out  DATA_W  to ALU A.
- alu_b  out  DATA_W  to ALU B.
- alu_out  in  DATA_W  from ALU ALUOut.
- alu_branch_enable  in  1  from ALU Branch_Enable.
- rsp_valid  out  1  response buffer holds a result.
- rsp_ready  in  1  consumer takes the response this cycle.
- rsp_id  out  1  requester that issued the buffered operation.
- rsp_aluout  out  DATA_W  registered ALUOut.
- rsp_branch_enable  out  1  registered Branch_Enable.
- grant_cnt0  out  CNT_W  saturating count of accepted r0 operations.
- grant_cnt1  out  CNT_W  saturating count of accepted r1 operations.

Behaviour:
- Reset (synchronous, reset=1 at an edge):
  - rsp_valid=0; rsp_id=0; rsp_aluout=0; rsp_branch_enable=0.
  - grant_cnt0=grant_cnt1=0.
  - last_grant=1, so requester 0 wins the first contention.
  - Any buffered response is discarded.
  - While reset is high, r0_ready=r1_ready=0.
- can_accept = !rsp_valid || rsp_ready. The buffer refills in the same cycle it drains.
- Grant is combinational:
  - Only one valid: that requester is granted.
  - Both valid: grant the requester != last_grant.
  - None valid: no grant.
- rX_ready = grantX && can_accept && !reset. rX_ready never asserts without rX_valid.
- ALU mux:
  - alu_ctl/a/b = requester 1 inputs when grant1, else requester 0 inputs.
  - The mux is purely combinational; there is no ALU latency.
- Accept edge (rX_valid && rX_ready):
  - rsp_aluout <= alu_out; rsp_branch_enable <= alu_branch_enable; rsp_id <= X.
  - rsp_valid <= 1; last_grant <= X.
  - grant_cntX increments, saturating at 2^CNT_W-1.
- Drain without accept (rsp_valid && rsp_ready, no accept): rsp_valid <= 0; data fields hold their last values.
- Backpressure (rsp_valid && !rsp_ready):
  - All rsp_* outputs stay stable.
  - Both readies stay 0.
  - last_grant and the counters are unchanged.
- Latency and throughput:
  - Accept at edge N gives rsp_valid high after edge N, so the response is visible in cycle N+1.
  - Sustained throughput is 1 op/cycle with rsp_ready held at 1.
  - Under continuous contention the grants alternate r0, r1, r0, ...
- Requester rules: requesters must hold valid and operands stable until ready. The arbiter does not check this.
- Width rules: results pass through bit-exact; there is no sign or width conversion.

Decomposition:
- Shared defines (sail-core defines include):
  - ALUctl width constant.
  - Requester id constants (ARB_ID_EXEC=0, ARB_ID_AUX=1).
- Existing ALUCTL_6to4 branch codes are reused unchanged.
- Sub-module rr_arb2 (round-robin arbiter):
  - Inputs: clk, reset, req[1:0], advance.
  - Output: one-hot grant[1:0].
  - Holds the last_grant flop.
- The top level holds the response buffer, ALU mux and counters.

Test Plan:
- Reset, then r0 issues a BEQ compare with A=0x0F, B=0x55, rsp_ready=1:
  - r0_ready=1 in cycle 0.
  - Cycle 1: rsp_valid=1, rsp_id=0, rsp_branch_enable=0.
- r1 alone issues a BNE compare with A=0x0E, B=0x55:
  - Response next cycle with rsp_id=1, rsp_branch_enable=1.
- Both valid for 4 cycles after reset, rsp_ready=1:
  - Accept order r0, r1, r0, r1.
  - grant_cnt0=2, grant_cnt1=2.
  - rsp_id sequence 0, 1, 0, 1.
- Backpressure: rsp_ready=0 for 3 cycles with the buffer full and both requesters valid:
  - Both readies are 0.
  - rsp_aluout/rsp_id are unchanged.
  - When rsp_ready rises, that same cycle drains and accepts the next op.
- Reset asserted while rsp_valid=1 and both requesters valid:
  - Next cycle rsp_valid=0 and the counters are 0.
  - The first grant after release goes to r0.
- CNT_W=4, r0 alone streams 20 BLTU ops (A=0, B=2):
  - grant_cnt0 saturates at 15.
  - Every response has rsp_branch_enable=1.
